rotation_adapter: RTL and testbench
===================================

Name: rotation_adapter

Overview:
- Frame-buffer adapter between a raster pixel source and a raster pixel sink.
- In load mode it stores one 256x256 8-bit greyscale image into internal single-port RAM.
- In rotate mode it streams the image out rotated 90 degrees clockwise, one pixel per clock.
- It flags output-row boundaries and frame completion.

Parameters:
- IMG_W, 256, image width in pixels (source columns)
- IMG_H, 256, image height in pixels (source rows); square images only, IMG_W = IMG_H
- DATA_W, 8, pixel width in bits
- ADDR_W, 16, RAM address width, log2(IMG_W*IMG_H)

Ports:
- clk  in  1  single system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = load/write frame, 1 = rotate/read frame
- data_in  in  DATA_W  source pixel, raster order (row-major, row 0 first)
- data_out  out  DATA_W  rotated pixel, raster order of the rotated image
- jump_out  out  1  one-cycle pulse marking the last pixel of each output row
- output_done  out  1  sticky flag: entire rotated frame has been emitted

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, wr_full=0, rd_idx=0, data_out=0, jump_out=0, output_done=0, mode_d (registered mode)=0.
  - RAM contents are not cleared.
- Load (mode=0):
  - Each rising edge with wr_full=0: RAM[wr_ptr] <= data_in, then wr_ptr increments.
  - When wr_ptr wraps from 65535 (IMG_W*IMG_H-1) to 0, wr_full is set and further writes are ignored. This means extra cycles spent in mode 0 never overwrite the frame.
  - data_out holds its value; jump_out=0.
- Rotate (mode=1):
  - Output index k = r*IMG_W + c, where r = output row and c = output column.
  - Pixel k is source pixel at row (IMG_H-1-c), column r, i.e. RAM address (IMG_H-1-c)*IMG_W + r.
  - Address generation uses counters r and c only; no multiplier. The address is the concatenation {~c, r} for the power-of-two size.
  - Cycle n = n-th rising edge with mode=1, starting at n=0:
    - The edge issues the read of k=n.
    - data_out presents pixel n after edge n+1, giving 1-cycle registered read latency.
    - The first edge with mode=1 leaves data_out at its previous value.
  - jump_out=1 during the cycle data_out presents a pixel with c=IMG_W-1; otherwise 0.
  - After k=65535 is issued, read counters stop.
  - On the next edge, data_out shows pixel 65535, jump_out=1, and output_done goes to 1.
  - From then on, data_out holds pixel 65535, jump_out=0 and output_done stays 1.
- Mode transitions (detected via mode_d):
  - 0->1: r, c, rd_idx cleared to 0; output_done cleared. Reading starts on that same edge.
  - 1->0, including mid-frame: read aborts, output_done cleared, wr_ptr=0 and wr_full=0 so a new frame can be loaded.
- Reset mid-operation:
  - All state returns to reset values immediately, independent of clk.
  - The RAM keeps data, but wr_full=0, so a new load restarts at address 0.
- Port contention: RAM is single-port. Writes occur only in mode 0 and reads only in mode 1, so no read/write collision exists.

Test Plan:
- Reset: hold rst=0 with random mode/data_in toggling -> data_out=0x00, jump_out=0, output_done=0 throughout.
- Load then rotate:
  - Write 65536 pixels with value(a) = a[7:0] XOR a[15:8], then stay 3 extra cycles in mode 0, then set mode=1.
  - Expected outputs: output k=0 -> 0xFF; k=1 -> 0xFE; k=256 -> 0xFE; k=65535 -> 0xFF.
  - The 3 extra cycles must not overwrite the frame.
- Row marker: during rotate -> jump_out pulses exactly 256 times. It is high only with output pixels k = 255, 511, ..., 65535.
- Completion: count edges after mode rises -> output_done rises exactly with pixel 65535 on data_out (edge 65536). It then stays 1, and data_out holds 0xFF.
- Abort and reload:
  - Drop mode to 0 at output k=1000 -> output_done=0.
  - Load a new frame of constant 0x5A, then mode=1 -> all 65536 outputs are 0x5A, and output_done rises at the end.
- Async reset mid-rotate: assert rst=0 at k=30000 between clock edges -> outputs clear immediately. After release, a new mode=0 load is written starting at address 0.

Source files
------------

// File: rtl/rotation_adapter.sv
// rotation_adapter: buffers one square greyscale frame in a single-port RAM and
// streams it back out rotated 90 degrees clockwise, one pixel per clock.
module rotation_adapter #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              jump_out,
  output logic              output_done
);

  localparam int                NPIX   = IMG_W * IMG_H;
  localparam int                CW     = $clog2(IMG_W);
  localparam logic [CW-1:0]     C_LAST = CW'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NPIX - 1);

  logic [DATA_W-1:0] mem [NPIX];

  logic              mode_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_full;
  logic [CW-1:0]     r;
  logic [CW-1:0]     c;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_active;

  logic              load_start;
  logic              rot_start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Mode edges, write enable/address and the rotated read address.
  // Dropping into load mode restarts the write pointer at 0 on that same edge,
  // so the first pixel presented with the falling mode lands at address 0.
  // Output pixel (r, c) lives at source row IMG_H-1-c, column r, which for a
  // power-of-two square is simply {~c, r}.
  always_comb begin
    load_start = ~mode & mode_d;
    rot_start  = mode & ~mode_d;
    wr_addr    = load_start ? '0 : wr_ptr;
    wr_en      = ~mode & (load_start | ~wr_full);
    rd_addr    = {~c, r};
  end

  // Write-side state: registered mode and the load pointer that locks once full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_d  <= 1'b0;
      wr_ptr  <= '0;
      wr_full <= 1'b0;
    end else begin
      mode_d <= mode;
      if (wr_en) begin
        wr_ptr  <= wr_addr + 1'b1;
        wr_full <= (wr_addr == K_LAST);
      end
    end
  end

  // Frame storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Read side: row/column counters, registered pixel output, row marker and done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r           <= '0;
      c           <= '0;
      rd_idx      <= '0;
      rd_active   <= 1'b0;
      data_out    <= '0;
      jump_out    <= 1'b0;
      output_done <= 1'b0;
    end else begin
      jump_out <= 1'b0;
      if (!mode) begin
        rd_active   <= 1'b0;
        output_done <= 1'b0;
      end else if (rot_start) begin
        r           <= '0;
        c           <= '0;
        rd_idx      <= '0;
        rd_active   <= 1'b1;
        output_done <= 1'b0;
      end else if (rd_active) begin
        data_out <= mem[rd_addr];
        jump_out <= (c == C_LAST);
        if (rd_idx == K_LAST) begin
          rd_active   <= 1'b0;
          output_done <= 1'b1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
          if (c == C_LAST) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rotation_adapter.sv
// tb_rotation_adapter: scoreboard bench for rotation_adapter on a reduced square frame.
module tb_rotation_adapter;

  localparam int W       = 32;
  localparam int H       = 32;
  localparam int DW      = 8;
  localparam int AW      = 10;
  localparam int NPIX    = W * H;
  localparam int ABORT_K = 1000;
  localparam int RESET_K = 600;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          jump;
    logic          done;
  } exp_t;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          jump_out;
  logic          output_done;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] model_mem [NPIX];
  exp_t          exp_q [$];

  rotation_adapter #(
    .IMG_W (W),
    .IMG_H (H),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .data_in    (data_in),
    .data_out   (data_out),
    .jump_out   (jump_out),
    .output_done(output_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] gen_pix(input int kind, input int a);
    case (kind)
      0:       return DW'(a % W) ^ DW'(a / W);
      1:       return 8'h5A;
      2:       return DW'($urandom);
      default: return DW'(a * 37 + 11);
    endcase
  endfunction

  // Output k of the rotated image: row r = k / W, column c = k % W,
  // taken from source row H-1-c, column r.
  function automatic logic [DW-1:0] exp_pix(input int k);
    int rr;
    int cc;
    rr = k / W;
    cc = k % W;
    return model_mem[(H - 1 - cc) * W + rr];
  endfunction

  // Load `count` pixels from address 0 then `extra` junk cycles; outputs must stay quiet.
  task automatic load_frame(input int kind, input int count, input int extra, input string tag);
    logic [DW-1:0] held;
    held = data_out;
    for (int a = 0; a < count + extra; a++) begin
      mode    = 1'b0;
      data_in = (a < count) ? gen_pix(kind, a) : DW'($urandom);
      if (a < count) model_mem[a] = data_in;
      tick();
      n_checks += 3;
      if (data_out !== held) begin
        n_fail++;
        $display("[TB] FAIL %s load hold a=%0d: got 0x%02h want 0x%02h", tag, a, data_out, held);
      end
      if (jump_out !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL %s load jump a=%0d: got %b want 0", tag, a, jump_out);
      end
      if (output_done !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL %s load done a=%0d: got %b want 0", tag, a, output_done);
      end
    end
  endtask

  // Raise mode for `edges` clocks; expectations are queued as each read is issued
  // and compared when the pixel appears one edge later.
  task automatic rotate_stream(input int edges, input string tag, output int jumps);
    exp_t          e;
    logic [DW-1:0] prev;
    jumps = 0;
    exp_q.delete();
    prev  = data_out;
    mode  = 1'b1;
    for (int n = 0; n < edges; n++) begin
      data_in = DW'($urandom);
      if (n < NPIX) begin
        e.data = exp_pix(n);
        e.jump = ((n % W) == W - 1);
        e.done = (n == NPIX - 1);
      end else begin
        e.data = exp_pix(NPIX - 1);
        e.jump = 1'b0;
        e.done = 1'b1;
      end
      exp_q.push_back(e);
      tick();
      if (n == 0) begin
        e = '{data: prev, jump: 1'b0, done: 1'b0};
      end else begin
        e = exp_q.pop_front();
      end
      n_checks += 3;
      if (data_out !== e.data) begin
        n_fail++;
        $display("[TB] FAIL %s data edge=%0d: got 0x%02h want 0x%02h", tag, n, data_out, e.data);
      end
      if (jump_out !== e.jump) begin
        n_fail++;
        $display("[TB] FAIL %s jump edge=%0d: got %b want %b", tag, n, jump_out, e.jump);
      end
      if (output_done !== e.done) begin
        n_fail++;
        $display("[TB] FAIL %s done edge=%0d: got %b want %b", tag, n, output_done, e.done);
      end
      if (jump_out === 1'b1) jumps++;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) begin
      n_checks += 3;
      if (data_out !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset data i=%0d: got 0x%02h want 0x00", i, data_out);
      end
      if (jump_out !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset jump i=%0d: got %b want 0", i, jump_out);
      end
      if (output_done !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset done i=%0d: got %b want 0", i, output_done);
      end
      mode    = 1'($urandom);
      data_in = DW'($urandom);
      tick();
    end
    mode    = 1'b0;
    data_in = '0;
    rst     = 1'b1;
  endtask

  task automatic test_load_rotate();
    int jumps;
    load_frame(0, NPIX, 3, "load_rotate");
    rotate_stream(NPIX + 4, "load_rotate", jumps);
    n_checks++;
    if (jumps != W) begin
      n_fail++;
      $display("[TB] FAIL row_marker count: got %0d want %0d", jumps, W);
    end
  endtask

  task automatic test_abort_reload();
    int jumps;
    load_frame(2, NPIX, 2, "abort_pre");
    rotate_stream(ABORT_K + 2, "abort_partial", jumps);
    load_frame(1, NPIX, 0, "abort_reload");
    rotate_stream(NPIX + 3, "abort_rotate", jumps);
    n_checks++;
    if (jumps != W) begin
      n_fail++;
      $display("[TB] FAIL abort row_marker count: got %0d want %0d", jumps, W);
    end
  endtask

  task automatic test_async_reset();
    int jumps;
    load_frame(2, NPIX, 1, "areset_pre");
    rotate_stream(RESET_K, "areset_partial", jumps);
    #2 rst = 1'b0;
    #1;
    n_checks += 3;
    if (data_out !== '0) begin
      n_fail++;
      $display("[TB] FAIL areset data: got 0x%02h want 0x00", data_out);
    end
    if (jump_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset jump: got %b want 0", jump_out);
    end
    if (output_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL areset done: got %b want 0", output_done);
    end
    mode = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    load_frame(2, 100, 0, "areset_partial_load");
    #2 rst = 1'b0;
    tick();
    rst = 1'b1;
    load_frame(3, NPIX, 0, "areset_reload");
    rotate_stream(NPIX + 2, "areset_rotate", jumps);
    n_checks++;
    if (jumps != W) begin
      n_fail++;
      $display("[TB] FAIL areset row_marker count: got %0d want %0d", jumps, W);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_load_rotate();
    test_abort_reload();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
